// File: rtl/icache.sv
// Direct-mapped read-only instruction cache between the Fetcher and the MemInter
// instruction port; a miss refills the whole line word 0 upward, then returns the requested word.
module icache #(
    parameter int INDEX_BITS  = 4,
    parameter int OFFSET_BITS = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic        f_valid,
    input  logic [31:0] f_addr,
    output logic        f_ready,
    output logic [31:0] f_data,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_result
);

    localparam int LINES  = 1 << INDEX_BITS;
    localparam int WORDS  = 1 << OFFSET_BITS;
    localparam int IDX_LO = OFFSET_BITS + 2;
    localparam int TAG_LO = OFFSET_BITS + INDEX_BITS + 2;
    localparam int TAG_W  = 32 - TAG_LO;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nx;
    logic [31:2]             r_req_addr;
    logic [31:2]             w_req_addr_nx;
    logic                    r_f_ready;
    logic                    w_f_ready_nx;
    logic [31:0]             r_f_data;
    logic [31:0]             w_f_data_nx;
    logic                    r_mem_valid;
    logic                    w_mem_valid_nx;
    logic [31:0]             r_mem_addr;
    logic [31:0]             w_mem_addr_nx;

    logic [LINES-1:0]        r_valid;
    logic [TAG_W-1:0]        r_tag  [LINES];
    logic [31:0]             r_data [LINES*WORDS];

    logic [INDEX_BITS-1:0]   w_f_idx;
    logic [OFFSET_BITS-1:0]  w_f_word;
    logic [TAG_W-1:0]        w_f_tag;
    logic [INDEX_BITS-1:0]   w_req_idx;
    logic [OFFSET_BITS-1:0]  w_req_word;
    logic [TAG_W-1:0]        w_req_tag;
    logic [OFFSET_BITS-1:0]  w_cur_word;
    logic                    w_hit;
    logic                    w_last;
    logic                    w_fill_we;
    logic                    w_valid_clr;
    logic                    w_valid_set;
    logic                    w_unused;

    assign w_f_idx    = f_addr[TAG_LO-1:IDX_LO];
    assign w_f_word   = f_addr[IDX_LO-1:2];
    assign w_f_tag    = f_addr[31:TAG_LO];
    assign w_req_idx  = r_req_addr[TAG_LO-1:IDX_LO];
    assign w_req_word = r_req_addr[IDX_LO-1:2];
    assign w_req_tag  = r_req_addr[31:TAG_LO];
    assign w_cur_word = r_mem_addr[IDX_LO-1:2];
    assign w_hit      = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign w_last     = (w_cur_word == {OFFSET_BITS{1'b1}});
    assign w_unused   = &{1'b0, f_addr[1:0]};

    assign f_ready    = r_f_ready;
    assign f_data     = r_f_data;
    assign mem_valid  = r_mem_valid;
    assign mem_addr   = r_mem_addr;

    // Next-state and next-output logic; rob_clear outranks every other event.
    always_comb begin
        w_state_nx     = r_state;
        w_req_addr_nx  = r_req_addr;
        w_f_ready_nx   = 1'b0;
        w_f_data_nx    = r_f_data;
        w_mem_valid_nx = r_mem_valid;
        w_mem_addr_nx  = r_mem_addr;
        w_fill_we      = 1'b0;
        w_valid_clr    = 1'b0;
        w_valid_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (f_valid && !rob_clear) begin
                    w_req_addr_nx = f_addr[31:2];
                    if (w_hit) begin
                        w_f_data_nx  = r_data[{w_f_idx, w_f_word}];
                        w_f_ready_nx = 1'b1;
                        w_state_nx   = S_DONE;
                    end else begin
                        w_valid_clr    = 1'b1;
                        w_mem_addr_nx  = {f_addr[31:IDX_LO], {OFFSET_BITS{1'b0}}, 2'b00};
                        w_mem_valid_nx = 1'b1;
                        w_state_nx     = S_REQ;
                    end
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_REQ: begin
                if (rob_clear) begin
                    w_mem_valid_nx = 1'b0;
                    w_state_nx     = S_IDLE;
                end else if (mem_ready) begin
                    w_fill_we      = 1'b1;
                    w_mem_valid_nx = 1'b0;
                    if (w_cur_word == w_req_word) begin
                        w_f_data_nx = mem_result;
                    end else begin
                        w_f_data_nx = r_f_data;
                    end
                    if (w_last) begin
                        w_valid_set  = 1'b1;
                        w_f_ready_nx = 1'b1;
                        w_state_nx   = S_DONE;
                    end else begin
                        w_state_nx = S_GAP;
                    end
                end else begin
                    w_state_nx = S_REQ;
                end
            end
            S_GAP: begin
                if (rob_clear) begin
                    w_mem_valid_nx = 1'b0;
                    w_state_nx     = S_IDLE;
                end else begin
                    w_mem_addr_nx  = r_mem_addr + 32'd4;
                    w_mem_valid_nx = 1'b1;
                    w_state_nx     = S_REQ;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_mem_valid_nx = 1'b0;
                w_state_nx     = S_IDLE;
            end
        endcase
    end

    // State and output registers; rdy_in low freezes everything.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= S_IDLE;
            r_req_addr  <= 30'd0;
            r_f_ready   <= 1'b0;
            r_f_data    <= 32'd0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= 32'd0;
        end else if (rdy_in) begin
            r_state     <= w_state_nx;
            r_req_addr  <= w_req_addr_nx;
            r_f_ready   <= w_f_ready_nx;
            r_f_data    <= w_f_data_nx;
            r_mem_valid <= w_mem_valid_nx;
            r_mem_addr  <= w_mem_addr_nx;
        end else begin
            r_state     <= r_state;
            r_req_addr  <= r_req_addr;
            r_f_ready   <= r_f_ready;
            r_f_data    <= r_f_data;
            r_mem_valid <= r_mem_valid;
            r_mem_addr  <= r_mem_addr;
        end
    end

    // Line valid bits: cleared on miss, set only when the last word lands.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_valid <= {LINES{1'b0}};
        end else if (rdy_in && w_valid_clr) begin
            r_valid[w_f_idx] <= 1'b0;
        end else if (rdy_in && w_valid_set) begin
            r_valid[w_req_idx] <= 1'b1;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Tag and data arrays carry no reset; the valid bits gate their use.
    always_ff @(posedge clk_in) begin
        if (rdy_in && w_fill_we) begin
            r_data[{w_req_idx, w_cur_word}] <= mem_result;
        end
        if (rdy_in && w_valid_set) begin
            r_tag[w_req_idx] <= w_req_tag;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: request table with scoreboarded returns and refill
// addresses, plus hand-written rob_clear, rdy_in and mid-refill reset sequences.
module tb_icache;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_clear;
    logic        f_valid;
    logic [31:0] f_addr;
    logic        f_ready;
    logic [31:0] f_data;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_result;

    logic        mem_en;
    logic        a_ready;
    logic [31:0] a_result;
    logic        m_ready;
    logic [31:0] m_result;
    int          cnt;
    logic        prev_mv;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_data_q[$];
    logic [31:0] exp_mem_q[$];

    typedef struct {
        logic [31:0] addr;
        logic        miss;
        logic        b2b;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    icache dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .rob_clear  (rob_clear),
        .f_valid    (f_valid),
        .f_addr     (f_addr),
        .f_ready    (f_ready),
        .f_data     (f_data),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_result (mem_result)
    );

    always #5 clk_in = ~clk_in;

    assign mem_ready  = mem_en ? a_ready  : m_ready;
    assign mem_result = mem_en ? a_result : m_result;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory responder: mem_ready pulses two cycles after mem_valid rises.
    always @(negedge clk_in) begin
        a_ready = 1'b0;
        if (mem_en && rdy_in && mem_valid) begin
            if (cnt == 1) begin
                a_ready  = 1'b1;
                a_result = 32'hA000_0000 | mem_addr;
                cnt      = 0;
            end else begin
                cnt = cnt + 1;
            end
        end else begin
            cnt = 0;
        end
    end

    // Scoreboard: returned words and each refill request address.
    always @(negedge clk_in) begin
        if (f_ready) begin
            if (exp_data_q.size() > 0) chk("f_data", f_data, exp_data_q.pop_front());
            else chk("unexpected_f_ready", {31'd0, f_ready}, 32'd0);
        end
        if (mem_valid && !prev_mv) begin
            if (exp_mem_q.size() > 0) chk("mem_addr", mem_addr, exp_mem_q.pop_front());
            else chk("unexpected_mem_valid", {31'd0, mem_valid}, 32'd0);
        end
        prev_mv = mem_valid;
    end

    task automatic do_req(input logic [31:0] addr, input logic miss, input logic b2b, input int lat);
        int got;
        got = 0;
        if (!b2b) repeat (2) @(negedge clk_in);
        exp_data_q.push_back(32'hA000_0000 | addr);
        if (miss) begin
            for (int w = 0; w < 4; w++) exp_mem_q.push_back((addr & 32'hFFFF_FFF0) + 32'(w * 4));
        end
        f_addr  = addr;
        f_valid = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk_in);
            #1;
            if (f_ready) begin
                got = i;
                break;
            end
        end
        chk("latency", 32'(got), 32'(lat));
        f_valid = 1'b0;
    endtask

    task automatic man_word(input logic clr);
        int i;
        i = 0;
        @(negedge clk_in);
        while (!mem_valid && i < 20) begin
            @(negedge clk_in);
            i++;
        end
        chk("man_wait_mem_valid", {31'd0, mem_valid}, 32'd1);
        m_ready   = 1'b1;
        m_result  = 32'hA000_0000 | mem_addr;
        rob_clear = clr;
        if (clr) f_valid = 1'b0;
        @(negedge clk_in);
        m_ready   = 1'b0;
        rob_clear = 1'b0;
    endtask

    initial begin
        int got;
        rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; f_valid = 1'b0; f_addr = 32'd0;
        mem_en = 1'b1; m_ready = 1'b0; m_result = 32'd0; a_ready = 1'b0; a_result = 32'd0;
        cnt = 0; prev_mv = 1'b0;
        #1 rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        chk("rst_f_ready", {31'd0, f_ready}, 32'd0);
        chk("rst_f_data", f_data, 32'd0);
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        rst_in = 1'b1;

        vecs[0] = '{32'h0000_0104, 1'b1, 1'b0, 12};
        vecs[1] = '{32'h0000_0108, 1'b0, 1'b0, 1};
        vecs[2] = '{32'h0000_010C, 1'b0, 1'b1, 2};
        vecs[3] = '{32'h0000_0100, 1'b0, 1'b1, 2};
        vecs[4] = '{32'h0000_0204, 1'b1, 1'b0, 12};
        vecs[5] = '{32'h0000_0104, 1'b1, 1'b0, 12};
        vecs[6] = '{32'h0000_0038, 1'b1, 1'b0, 12};
        vecs[7] = '{32'h0000_0034, 1'b0, 1'b0, 1};
        vecs[8] = '{32'h0000_0200, 1'b1, 1'b0, 12};
        for (int k = 0; k < 9; k++) do_req(vecs[k].addr, vecs[k].miss, vecs[k].b2b, vecs[k].lat);

        // rob_clear on the final-word... here on word 2 of a refill at 0x300.
        mem_en = 1'b0;
        repeat (2) @(negedge clk_in);
        exp_mem_q.push_back(32'h0000_0300);
        exp_mem_q.push_back(32'h0000_0304);
        exp_mem_q.push_back(32'h0000_0308);
        f_addr = 32'h0000_0300; f_valid = 1'b1;
        man_word(1'b0);
        man_word(1'b0);
        man_word(1'b1);
        chk("rob_mem_valid_off", {31'd0, mem_valid}, 32'd0);
        repeat (4) @(negedge clk_in);
        chk("rob_stays_idle", {31'd0, mem_valid}, 32'd0);
        mem_en = 1'b1;
        do_req(32'h0000_0300, 1'b1, 1'b0, 12);

        // rdy_in low for 3 cycles in REQ, with a stray mem_ready while frozen.
        mem_en = 1'b0;
        repeat (2) @(negedge clk_in);
        for (int w = 0; w < 4; w++) exp_mem_q.push_back(32'h0000_0100 + 32'(w * 4));
        exp_data_q.push_back(32'hA000_0104);
        f_addr = 32'h0000_0104; f_valid = 1'b1;
        @(negedge clk_in);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_ready  = (i == 1);
            m_result = 32'hDEAD_BEEF;
            @(negedge clk_in);
            chk("frz_mem_valid", {31'd0, mem_valid}, 32'd1);
            chk("frz_mem_addr", mem_addr, 32'h0000_0100);
        end
        m_ready = 1'b0;
        rdy_in  = 1'b1;
        mem_en  = 1'b1;
        got = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk_in);
            #1;
            if (f_ready) begin
                got = 1;
                break;
            end
        end
        chk("frz_resume_done", 32'(got), 32'd1);
        f_valid = 1'b0;
        do_req(32'h0000_0100, 1'b0, 1'b0, 1);

        // Asynchronous reset in the middle of a refill.
        repeat (2) @(negedge clk_in);
        exp_mem_q.push_back(32'h0000_0040);
        f_addr = 32'h0000_0040; f_valid = 1'b1;
        got = 0;
        while (!mem_valid && got < 20) begin
            @(negedge clk_in);
            got++;
        end
        #1 rst_in = 1'b0;
        #1;
        chk("arst_f_ready", {31'd0, f_ready}, 32'd0);
        chk("arst_f_data", f_data, 32'd0);
        chk("arst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("arst_mem_addr", mem_addr, 32'd0);
        f_valid = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        do_req(32'h0000_0108, 1'b1, 1'b0, 12);
        do_req(32'h0000_0040, 1'b1, 1'b0, 12);

        repeat (4) @(negedge clk_in);
        chk("data_q_drained", 32'(exp_data_q.size()), 32'd0);
        chk("mem_q_drained", 32'(exp_mem_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
